forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_if.sv | 33 +++
 rtl/forward_ctrl.sv | 86 ++++++++
 tb/tb_forward_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/forward_ctrl_if.sv
// Bundles the EX-stage, source-port and control signals of the forwarding
// controller; the pipeline drives it through master, the controller reads it through slave.
interface forward_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                    ex_valid;
  logic [4:0]              ex_rd;
  logic                    ex_we;
  logic                    ex_is_load;
  logic [NUM_SRC-1:0]      src_valid;
  logic [5*NUM_SRC-1:0]    src_reg;
  logic                    fwd_en;
  logic                    freeze;
  logic                    flush;
  logic [SELW*NUM_SRC-1:0] fwd_sel;
  logic                    hazard_stall;
  logic [15:0]             stall_cnt;

  modport master (
    output ex_valid, ex_rd, ex_we, ex_is_load, src_valid, src_reg,
           fwd_en, freeze, flush,
    input  fwd_sel, hazard_stall, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_rd, ex_we, ex_is_load, src_valid, src_reg,
           fwd_en, freeze, flush,
    output fwd_sel, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/forward_ctrl.sv
// Operand-forwarding and load-use hazard controller: tracks the destination
// registers of in-flight instructions and picks the youngest producer per source port.
module forward_ctrl #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
) (
  input  logic           clk,
  input  logic           rst,
  forward_ctrl_if.slave  bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } entry_t;

  entry_t                  entries_q [1:DEPTH];
  entry_t                  entries_d [1:DEPTH];
  logic [15:0]             stallCnt_q;
  logic [15:0]             stallCnt_d;
  logic [SELW*NUM_SRC-1:0] selComb;
  logic                    anyMatch;
  logic                    loadUse;
  logic                    hazardRaw;

  function automatic logic isWriter(entry_t e);
    return e.valid && e.we && (e.rd != 5'd0);
  endfunction

  // Scan from the oldest stage down so the youngest matching producer overwrites older ones.
  always_comb begin
    selComb  = '0;
    anyMatch = 1'b0;
    loadUse  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (bus.src_valid[i] && (bus.src_reg[5*i +: 5] != 5'd0) &&
            isWriter(entries_q[k]) && (entries_q[k].rd == bus.src_reg[5*i +: 5])) begin
          selComb[SELW*i +: SELW] = SELW'(k);
          anyMatch = 1'b1;
          if ((k == 1) && entries_q[1].is_load) begin
            loadUse = 1'b1;
          end
        end
      end
    end
  end

  assign hazardRaw        = bus.fwd_en ? loadUse : anyMatch;
  assign bus.hazard_stall = rst ? 1'b0 : hazardRaw;
  assign bus.fwd_sel      = (rst || !bus.fwd_en) ? '0 : selComb;
  assign bus.stall_cnt    = stallCnt_q;

  // A stalled or flushed EX instruction enters the tracker as a bubble.
  always_comb begin
    entries_d  = entries_q;
    stallCnt_d = stallCnt_q;
    if (!bus.freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      if (bus.flush || hazardRaw) begin
        entries_d[1] = '0;
      end else begin
        entries_d[1] = '{valid: bus.ex_valid, rd: bus.ex_rd,
                         we: bus.ex_we, is_load: bus.ex_is_load};
      end
      if (hazardRaw && (stallCnt_q != 16'hFFFF)) begin
        stallCnt_d = stallCnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q  <= '{default: '0};
      stallCnt_q <= '0;
    end else begin
      entries_q  <= entries_d;
      stallCnt_q <= stallCnt_d;
    end
  end
endmodule

// File: tb/tb_forward_ctrl.sv
// Directed scoreboard bench for forward_ctrl with NUM_SRC=2, DEPTH=3.
module tb_forward_ctrl;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;

  typedef struct {
    string       tag;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        haz;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  forward_ctrl_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

  forward_ctrl #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setEx(input logic v, input logic [4:0] rd, input logic we, input logic ld);
    bus.ex_valid   = v;
    bus.ex_rd      = rd;
    bus.ex_we      = we;
    bus.ex_is_load = ld;
  endtask

  task automatic setSrc(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    bus.src_valid = v;
    bus.src_reg   = {r1, r0};
  endtask

  task automatic setCtl(input logic fe, input logic frz, input logic fl);
    bus.fwd_en = fe;
    bus.freeze = frz;
    bus.flush  = fl;
  endtask

  // Inputs are already on the bus; record what this cycle must produce.
  task automatic applyStimulus(input string tag, input logic [1:0] s0, input logic [1:0] s1,
                               input logic h, input logic [15:0] c);
    exp_t e;
    e.tag  = tag;
    e.sel0 = s0;
    e.sel1 = s1;
    e.haz  = h;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard empty got=0 want=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.fwd_sel[1:0] === e.sel0) else begin
        failures++;
        $error("[TB] FAIL %s sel0 got=%0d want=%0d", e.tag, bus.fwd_sel[1:0], e.sel0);
      end
      checks++;
      assert (bus.fwd_sel[3:2] === e.sel1) else begin
        failures++;
        $error("[TB] FAIL %s sel1 got=%0d want=%0d", e.tag, bus.fwd_sel[3:2], e.sel1);
      end
      checks++;
      assert (bus.hazard_stall === e.haz) else begin
        failures++;
        $error("[TB] FAIL %s hazard got=%0b want=%0b", e.tag, bus.hazard_stall, e.haz);
      end
      checks++;
      assert (bus.stall_cnt === e.cnt) else begin
        failures++;
        $error("[TB] FAIL %s stall_cnt got=%0d want=%0d", e.tag, bus.stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    setCtl(1, 0, 0);
    setEx(1, 5, 1, 0);
    setSrc(2'b01, 5, 0);
    applyStimulus("reset", 0, 0, 0, 0);
    checkOutput();
    nextCycle();

    rst = 1'b0;
    setEx(1, 5, 1, 0); setSrc(2'b00, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 6, 1, 0); setSrc(2'b01, 5, 0);
    applyStimulus("back2back", 1, 0, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 5, 1, 0); setSrc(2'b11, 5, 6);
    applyStimulus("stage1_2", 2, 1, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 5, 1, 0); setSrc(2'b11, 5, 6);
    applyStimulus("dbl_writer_a", 1, 2, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 9, 0, 0); setSrc(2'b11, 5, 6);
    applyStimulus("dbl_writer_b", 1, 3, 0, 0);
    checkOutput(); nextCycle();

    setEx(0, 0, 0, 0); setSrc(2'b11, 5, 9);
    applyStimulus("skip_nonwriter", 2, 0, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 0, 1, 0); setSrc(2'b11, 5, 0);
    applyStimulus("last_stage", 3, 0, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 7, 1, 1); setSrc(2'b11, 0, 0);
    applyStimulus("x0_writer", 0, 0, 0, 0);
    checkOutput(); nextCycle();

    setEx(1, 8, 1, 0); setSrc(2'b01, 7, 0);
    applyStimulus("load_use", 1, 0, 1, 0);
    checkOutput(); nextCycle();

    setEx(1, 8, 1, 0); setSrc(2'b01, 7, 0);
    applyStimulus("after_load_use", 2, 0, 0, 1);
    checkOutput(); nextCycle();

    setEx(1, 10, 1, 1); setSrc(2'b00, 0, 0);
    applyStimulus("issue_load", 0, 0, 0, 1);
    checkOutput(); nextCycle();

    setEx(1, 11, 1, 0); setSrc(2'b01, 10, 0); setCtl(1, 1, 0);
    applyStimulus("freeze_a", 1, 0, 1, 1);
    checkOutput(); nextCycle();

    applyStimulus("freeze_b", 1, 0, 1, 1);
    checkOutput(); nextCycle();

    setCtl(1, 0, 0);
    applyStimulus("unfreeze", 1, 0, 1, 1);
    checkOutput(); nextCycle();

    setEx(1, 12, 1, 0); setSrc(2'b11, 10, 8); setCtl(1, 0, 1);
    applyStimulus("flush_issue", 2, 3, 0, 2);
    checkOutput(); nextCycle();

    setEx(0, 0, 0, 0); setSrc(2'b11, 12, 10); setCtl(1, 0, 0);
    applyStimulus("flush_gone", 0, 3, 0, 2);
    checkOutput(); nextCycle();

    setEx(1, 13, 1, 1); setSrc(2'b00, 0, 0);
    applyStimulus("issue_load2", 0, 0, 0, 2);
    checkOutput(); nextCycle();

    setEx(1, 14, 1, 0); setSrc(2'b01, 13, 0); setCtl(1, 0, 1);
    applyStimulus("flush_and_stall", 1, 0, 1, 2);
    checkOutput(); nextCycle();

    setEx(0, 0, 0, 0); setSrc(2'b11, 14, 13); setCtl(1, 0, 0);
    applyStimulus("after_flush_stall", 0, 2, 0, 3);
    checkOutput(); nextCycle();

    setEx(1, 15, 1, 0); setSrc(2'b00, 0, 0);
    applyStimulus("issue_x15", 0, 0, 0, 3);
    checkOutput(); nextCycle();

    setEx(0, 0, 0, 0); setSrc(2'b00, 0, 0);
    applyStimulus("idle2", 0, 0, 0, 3);
    checkOutput(); nextCycle();

    setEx(1, 16, 1, 0); setSrc(2'b01, 15, 0); setCtl(0, 0, 0);
    applyStimulus("nofwd_stage2", 0, 0, 1, 3);
    checkOutput(); nextCycle();

    applyStimulus("nofwd_stage3", 0, 0, 1, 4);
    checkOutput(); nextCycle();

    applyStimulus("nofwd_released", 0, 0, 0, 5);
    checkOutput(); nextCycle();

    setEx(0, 0, 0, 0); setSrc(2'b11, 16, 16); setCtl(1, 0, 0);
    applyStimulus("x16_fwd", 1, 1, 0, 5);
    checkOutput(); nextCycle();

    rst = 1'b1;
    applyStimulus("mid_reset", 0, 0, 0, 0);
    checkOutput(); nextCycle();

    rst = 1'b0;
    applyStimulus("post_reset", 0, 0, 0, 0);
    checkOutput(); nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
